mure_slot_sequencer: RTL and testbench
======================================

# mure_slot_sequencer

Controller for the per-commit-port uop FIFOs of the multiple-retirement trace path. It decides which FIFO head feeds the block-building FSM each cycle, skips empty retirement slots, and cuts a group short on an exception or interrupt. It pops all port FIFOs together once a retirement group is consumed, and applies downstream backpressure. It also reports stalls and FIFO desynchronisation.

## Interface
Parameters:
- NRET, 2, number of commit ports (FIFOs), ≥1
- ITYPE_LEN, 3, itype field width
- STALL_MAX, 8, consecutive not-ready cycles before stall_o asserts, ≥1
- SEL_W, (NRET>1 ? $clog2(NRET) : 1), select width (derived)

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  reset, asynchronous, active-low
- empty_i  in  NRET  per-FIFO empty flags
- head_valid_i  in  NRET  valid bit of each FIFO head entry
- head_itype_i  in  NRET×ITYPE_LEN  itype of each FIFO head entry
- ready_i  in  1  downstream (FSM) accepts offered entry
- flush_i  in  1  synchronous group abort
- sel_o  out  SEL_W  mux select of head entry offered
- valid_o  out  1  selected entry offered downstream
- last_o  out  1  offered entry is final of its group
- pop_o  out  1  pop all port FIFOs
- stall_o  out  1  downstream stalled ≥STALL_MAX cycles
- err_o  out  1  sticky: empty_i flags disagree
- group_cnt_o  out  16  groups popped, wraps

## Operation
- Group present when empty_i[0]==0. All FIFOs push and pop together, so the heads form one retirement group.
- Slot i is live when head_valid_i[i]==1, or when head_itype_i[i]∈{1,2}, regardless of valid.
- Register idx (0..NRET-1) holds the next slot to examine.
- State IDLE: idx==0, no entry accepted from the current group.
- State ACTIVE: at least one non-last entry of the current group has been accepted.
- sel_o = lowest live slot ≥ idx. Non-live slots are skipped combinationally and cost zero cycles.
- valid_o = group present AND a live slot ≥ idx exists AND !flush_i.
- last_o = valid_o AND (selected slot itype∈{1,2} OR no live slot above sel_o). Slots after an exception/interrupt slot are discarded.
- Handshake when valid_o && ready_i:
  - if last_o: pop_o=1, idx←0, state→IDLE, group_cnt_o+1
  - else: idx←sel_o+1, state→ACTIVE
- Empty group (present, no live slot ≥ idx, no flush): pop_o=1 with valid_o=0, idx←0, →IDLE, group_cnt_o+1.
- pop_o is asserted only in the cycle of the final handshake or empty-group drop. The FIFO heads change the next cycle.
- flush_i: valid_o=0 and pop_o=0 that cycle, idx←0, →IDLE, stall counter cleared. Flushing the FIFO contents is external.
- Stall counter (saturating at STALL_MAX):
  - increments when valid_o && !ready_i
  - clears on handshake or flush
- stall_o = counter==STALL_MAX.
- err_o is set when empty_i is neither all-0 nor all-1. It clears only on reset. Sequencing uses empty_i[0] regardless.
- While valid_o && !ready_i, sel_o and last_o stay stable; the inputs are FIFO heads and do not change without a pop.

## Timing
- Reset values: sel_o=0, valid_o=0, last_o=0, pop_o=0, stall_o=0, err_o=0, group_cnt_o=0, idx=0, state IDLE.
- valid_o, sel_o, last_o and pop_o are combinational from registered state and FIFO heads. A non-empty FIFO is offered in the same cycle.
- A group with k live slots, under constant ready, takes k cycles; its pop is in cycle k. A group with no live slots takes 1 cycle.
- Throughput is one entry per cycle. Back-to-back groups carry no bubble, because the next head is offered in the cycle after the pop.
- stall_o rises in the STALL_MAX-th consecutive stalled cycle, registered, and falls the cycle after the handshake.
- Reset mid-group: immediate return to the reset state. Group progress is lost.
- flush_i together with ready_i: flush wins and there is no handshake.
- group_cnt_o wraps from 0xFFFF to 0.

## Test plan
- NRET=2, both heads valid, itype 0, ready=1: cycle0 sel=0 valid last=0; cycle1 sel=1 last=1 pop=1; group_cnt_o=1.
- Head0 valid=0 itype 0, head1 valid=1 itype 4: single cycle sel=1 valid last pop; no output for slot 0.
- Head0 itype=1 (exception), head1 valid itype 0: sel=0 last=1 pop=1 in cycle0; slot 1 is never offered.
- STALL_MAX=4, ready=0 for 6 cycles on slot 0: sel/last stable, stall_o=1 from cycle 3; ready=1 then handshake, stall_o=0 next cycle.
- Both heads valid=0 itype 0: pop=1 with valid=0 in one cycle; group_cnt_o increments. Then empty_i=2'b01: err_o=1 and stays set.
- After slot 0 accepted (ACTIVE), flush_i=1: no pop, next cycle sel=0 offered again. Repeat with rst_ni low mid-group: all outputs return to reset values.

Source files
------------

// File: rtl/mure_slot_sequencer.sv
// Sequences retirement-slot FIFO heads into the block-building FSM, one live slot per cycle.
// Offer/pop are combinational from state and heads; stall_o is registered, err_o is sticky.
module mure_slot_sequencer #(
  parameter int NRET      = 2,
  parameter int ITYPE_LEN = 3,
  parameter int STALL_MAX = 8,
  parameter int SEL_W     = (NRET > 1) ? $clog2(NRET) : 1
) (
  input  logic                               clk_i,
  input  logic                               rst_ni,
  input  logic [NRET-1:0]                    empty_i,
  input  logic [NRET-1:0]                    head_valid_i,
  input  logic [NRET-1:0][ITYPE_LEN-1:0]     head_itype_i,
  input  logic                               ready_i,
  input  logic                               flush_i,
  output logic [SEL_W-1:0]                   sel_o,
  output logic                               valid_o,
  output logic                               last_o,
  output logic                               pop_o,
  output logic                               stall_o,
  output logic                               err_o,
  output logic [15:0]                        group_cnt_o
);

  typedef enum logic {IDLE, ACTIVE} state_e;
  localparam int CNT_W = $clog2(STALL_MAX + 1);

  state_e            r_state;
  logic [SEL_W-1:0]  r_idx;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_stall;
  logic              r_err;
  logic [15:0]       r_grp;

  logic [NRET-1:0]   w_live;
  logic [SEL_W-1:0]  w_idx;
  logic [SEL_W-1:0]  w_sel;
  logic              w_found;
  logic              w_more;
  logic              w_sel_exc;
  logic              w_present;
  logic              w_valid;
  logic              w_last;
  logic              w_hs;
  logic              w_drop;
  logic              w_pop;

  // Exception/interrupt itypes (1, 2) make a slot live even without its valid bit.
  always_comb begin
    for (int i = 0; i < NRET; i++) begin
      w_live[i] = head_valid_i[i] ||
                  (head_itype_i[i] == ITYPE_LEN'(1)) ||
                  (head_itype_i[i] == ITYPE_LEN'(2));
    end
  end

  assign w_idx = (r_state == IDLE) ? '0 : r_idx;

  always_comb begin
    w_sel   = '0;
    w_found = 1'b0;
    for (int i = 0; i < NRET; i++) begin
      if (!w_found && w_live[i] && (i >= int'(w_idx))) begin
        w_sel   = SEL_W'(i);
        w_found = 1'b1;
      end
    end
    w_more = 1'b0;
    for (int i = 0; i < NRET; i++) begin
      if (w_live[i] && (i > int'(w_sel))) begin
        w_more = 1'b1;
      end
    end
  end

  assign w_sel_exc = (head_itype_i[w_sel] == ITYPE_LEN'(1)) ||
                     (head_itype_i[w_sel] == ITYPE_LEN'(2));

  assign w_present = !empty_i[0];
  assign w_valid   = w_present && w_found && !flush_i;
  assign w_last    = w_valid && (w_sel_exc || !w_more);
  assign w_hs      = w_valid && ready_i;
  assign w_drop    = w_present && !w_found && !flush_i;
  assign w_pop     = (w_hs && w_last) || w_drop;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= IDLE;
      r_idx   <= '0;
      r_cnt   <= '0;
      r_stall <= 1'b0;
      r_err   <= 1'b0;
      r_grp   <= '0;
    end else begin
      if (flush_i) begin
        r_state <= IDLE;
        r_idx   <= '0;
        r_cnt   <= '0;
        r_stall <= 1'b0;
      end else begin
        if (w_pop) begin
          r_state <= IDLE;
          r_idx   <= '0;
        end else if (w_hs) begin
          r_state <= ACTIVE;
          r_idx   <= w_sel + SEL_W'(1);
        end
        // Flag is set one cycle early so it is visible in the STALL_MAX-th stalled cycle.
        if (w_hs) begin
          r_cnt   <= '0;
          r_stall <= 1'b0;
        end else if (w_valid) begin
          if (int'(r_cnt) < STALL_MAX) r_cnt <= r_cnt + CNT_W'(1);
          if (int'(r_cnt) + 1 >= STALL_MAX - 1) r_stall <= 1'b1;
        end
      end
      if (w_pop) r_grp <= r_grp + 16'd1;
      if ((empty_i != '0) && (empty_i != '1)) r_err <= 1'b1;
    end
  end

  assign sel_o       = w_sel;
  assign valid_o     = w_valid;
  assign last_o      = w_last;
  assign pop_o       = w_pop;
  assign stall_o     = r_stall;
  assign err_o       = r_err;
  assign group_cnt_o = r_grp;

endmodule

// File: tb/tb_mure_slot_sequencer.sv
// Vector table plus hand sequences for stall, error, flush and reset corners of the slot sequencer.
module tb_mure_slot_sequencer;

  logic              clk_i = 1'b0;
  logic              rst_ni;
  logic [1:0]        empty_i;
  logic [1:0]        head_valid_i;
  logic [1:0][2:0]   head_itype_i;
  logic              ready_i;
  logic              flush_i;
  logic [0:0]        sel_o;
  logic              valid_o;
  logic              last_o;
  logic              pop_o;
  logic              stall_o;
  logic              err_o;
  logic [15:0]       group_cnt_o;

  int n_vec = 0;
  int n_err = 0;

  typedef struct packed {
    logic [1:0]  empty;
    logic [1:0]  hv;
    logic [2:0]  it1;
    logic [2:0]  it0;
    logic        rdy;
    logic        fl;
    logic        sel;
    logic        vld;
    logic        lst;
    logic        pop;
    logic [15:0] grp;
  } vec_t;

  typedef struct packed {
    logic        sel;
    logic        vld;
    logic        lst;
    logic        pop;
    logic [15:0] grp;
  } exp_t;

  exp_t sbq[$];
  vec_t tbl[17];

  mure_slot_sequencer #(.NRET(2), .ITYPE_LEN(3), .STALL_MAX(4)) dut (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .empty_i      (empty_i),
    .head_valid_i (head_valid_i),
    .head_itype_i (head_itype_i),
    .ready_i      (ready_i),
    .flush_i      (flush_i),
    .sel_o        (sel_o),
    .valid_o      (valid_o),
    .last_o       (last_o),
    .pop_o        (pop_o),
    .stall_o      (stall_o),
    .err_o        (err_o),
    .group_cnt_o  (group_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  function automatic vec_t mk(input logic [1:0] empty, input logic [1:0] hv,
                              input logic [2:0] it1, input logic [2:0] it0,
                              input logic rdy, input logic fl,
                              input logic sel, input logic vld, input logic lst,
                              input logic pop, input logic [15:0] grp);
    vec_t v;
    v.empty = empty; v.hv = hv; v.it1 = it1; v.it0 = it0; v.rdy = rdy; v.fl = fl;
    v.sel = sel; v.vld = vld; v.lst = lst; v.pop = pop; v.grp = grp;
    return v;
  endfunction

  task automatic check_out(input string nm);
    exp_t e;
    exp_t a;
    e = sbq.pop_front();
    a = {sel_o, valid_o, last_o, pop_o, group_cnt_o};
    n_vec++;
    if (a !== e) begin
      n_err++;
      $display("FAIL %s: got sel=%0d vld=%0b lst=%0b pop=%0b grp=%0d, want sel=%0d vld=%0b lst=%0b pop=%0b grp=%0d",
               nm, a.sel, a.vld, a.lst, a.pop, a.grp, e.sel, e.vld, e.lst, e.pop, e.grp);
    end
  endtask

  task automatic check_bit(input string nm, input logic act, input logic exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0b, want %0b", nm, act, exp);
    end
  endtask

  // Drive at the falling edge, sample the combinational outputs before the next rising edge.
  task automatic drive(input vec_t v, input string nm);
    @(negedge clk_i);
    empty_i         = v.empty;
    head_valid_i    = v.hv;
    head_itype_i[1] = v.it1;
    head_itype_i[0] = v.it0;
    ready_i         = v.rdy;
    flush_i         = v.fl;
    sbq.push_back({v.sel, v.vld, v.lst, v.pop, v.grp});
    #2;
    check_out(nm);
  endtask

  initial begin
    rst_ni       = 1'b0;
    empty_i      = 2'b11;
    head_valid_i = 2'b00;
    head_itype_i = '0;
    ready_i      = 1'b0;
    flush_i      = 1'b0;

    //                 empty  hv     it1   it0   rdy   fl    sel   vld   lst   pop   grp
    tbl[0]  = mk(2'b00, 2'b11, 3'd0, 3'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'd0);
    tbl[1]  = mk(2'b00, 2'b11, 3'd0, 3'd0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 16'd0);
    tbl[2]  = mk(2'b00, 2'b10, 3'd4, 3'd0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 16'd1);
    tbl[3]  = mk(2'b00, 2'b11, 3'd0, 3'd1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 16'd2);
    tbl[4]  = mk(2'b00, 2'b00, 3'd0, 3'd2, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 16'd3);
    tbl[5]  = mk(2'b00, 2'b00, 3'd0, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'd4);
    tbl[6]  = mk(2'b11, 2'b00, 3'd0, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd5);
    tbl[7]  = mk(2'b00, 2'b11, 3'd1, 3'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'd5);
    tbl[8]  = mk(2'b00, 2'b11, 3'd1, 3'd0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 16'd5);
    tbl[9]  = mk(2'b00, 2'b01, 3'd0, 3'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 16'd6);
    tbl[10] = mk(2'b00, 2'b11, 3'd0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'd7);
    tbl[11] = mk(2'b00, 2'b11, 3'd0, 3'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'd7);
    tbl[12] = mk(2'b00, 2'b11, 3'd0, 3'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'd7);
    tbl[13] = mk(2'b00, 2'b11, 3'd0, 3'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 16'd7);
    tbl[14] = mk(2'b00, 2'b11, 3'd0, 3'd0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 16'd7);
    tbl[15] = mk(2'b00, 2'b11, 3'd0, 3'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'd7);
    tbl[16] = mk(2'b00, 2'b11, 3'd0, 3'd0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 16'd7);

    repeat (2) @(negedge clk_i);
    sbq.push_back({1'b0, 1'b0, 1'b0, 1'b0, 16'd0});
    #2;
    check_out("reset_outputs");
    check_bit("reset_stall", stall_o, 1'b0);
    check_bit("reset_err", err_o, 1'b0);
    @(negedge clk_i);
    rst_ni = 1'b1;

    for (int i = 0; i < 17; i++) begin
      drive(tbl[i], $sformatf("tbl%0d", i));
    end

    // Six stalled cycles on slot 0: stall_o visible from the fourth.
    for (int c = 0; c < 6; c++) begin
      drive(mk(2'b00, 2'b11, 3'd0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'd8),
            $sformatf("stall_hold%0d", c));
      check_bit($sformatf("stall_o_c%0d", c), stall_o, (c >= 3));
    end
    drive(mk(2'b00, 2'b11, 3'd0, 3'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'd8), "stall_hs");
    check_bit("stall_o_at_hs", stall_o, 1'b1);
    drive(mk(2'b00, 2'b11, 3'd0, 3'd0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 16'd8), "stall_after");
    check_bit("stall_o_after_hs", stall_o, 1'b0);

    drive(mk(2'b11, 2'b00, 3'd0, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd9), "err_pre");
    check_bit("err_pre", err_o, 1'b0);
    drive(mk(2'b01, 2'b11, 3'd0, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd9), "err_desync");
    drive(mk(2'b11, 2'b00, 3'd0, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd9), "err_post0");
    check_bit("err_set", err_o, 1'b1);
    drive(mk(2'b11, 2'b00, 3'd0, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd9), "err_post1");
    check_bit("err_sticky", err_o, 1'b1);

    // Reset in the middle of a stalled group.
    drive(mk(2'b00, 2'b11, 3'd0, 3'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'd9), "rst_slot0");
    for (int c = 0; c < 4; c++) begin
      drive(mk(2'b00, 2'b11, 3'd0, 3'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 16'd9),
            $sformatf("rst_hold%0d", c));
    end
    check_bit("rst_pre_stall", stall_o, 1'b1);
    @(negedge clk_i);
    rst_ni = 1'b0;
    #2;
    check_bit("rst_stall", stall_o, 1'b0);
    check_bit("rst_err", err_o, 1'b0);
    check_bit("rst_sel", sel_o, 1'b0);
    n_vec++;
    if (group_cnt_o !== 16'd0) begin
      n_err++;
      $display("FAIL rst_grp: got %0d, want 0", group_cnt_o);
    end
    @(negedge clk_i);
    rst_ni = 1'b1;
    drive(mk(2'b00, 2'b11, 3'd0, 3'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'd0), "post_rst0");
    drive(mk(2'b00, 2'b11, 3'd0, 3'd0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 16'd0), "post_rst1");
    drive(mk(2'b11, 2'b00, 3'd0, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd1), "post_rst2");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
